// File: rtl/add_share_arbiter_if.sv
// Request/response bundle between R fixed-point clients and the shared adder arbiter.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
interface add_share_arbiter_if #(
    parameter int N = 32,
    parameter int R = 4
);
    localparam int IDW = (R > 1) ? $clog2(R) : 1;

    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_ready;
    logic [R*N-1:0] req_a;
    logic [R*N-1:0] req_b;
    logic [R-1:0]   req_ci;
    logic [R-1:0]   req_chain;
    logic [R-1:0]   req_lock;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [N-1:0]   rsp_c;
    logic           rsp_co;

    // Lock FSM visibility for checkers.
    logic           dbg_locked;
    logic [IDW-1:0] dbg_owner;

    modport master (
        output req_valid, req_a, req_b, req_ci, req_chain, req_lock, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_c, rsp_co, dbg_locked, dbg_owner
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ci, req_chain, req_lock, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_c, rsp_co, dbg_locked, dbg_owner
    );
endinterface

// File: rtl/add_share_arbiter.sv
// Round-robin arbiter sharing one N-bit adder among R requesters, with a lock
// so one requester can run a multi-word add using its own stored carry.
module add_share_arbiter #(
    parameter int N = 32,
    parameter int R = 4
) (
    input logic                clk,
    input logic                rst,
    add_share_arbiter_if.slave bus
);
    localparam int IDW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic {
        ST_FREE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    lock_state_e    state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [R-1:0]   cy_q, cy_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [N-1:0]   rsp_c_q, rsp_c_d;
    logic           rsp_co_q, rsp_co_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;

    logic           acc_en;
    logic           gnt_any;
    logic [IDW-1:0] gnt_idx;
    logic           xfer;
    logic [N-1:0]   add_a, add_b, add_c;
    logic           add_ci, add_co;

    // First valid requester at or after the pointer, wrapping modulo R.
    function automatic logic [IDW:0] rr_pick(input logic [R-1:0] v, input logic [IDW-1:0] p);
        logic           found;
        logic [IDW-1:0] pick;
        int             idx;
        found = 1'b0;
        pick  = '0;
        for (int off = 0; off < R; off++) begin
            idx = int'(p) + off;
            if (idx >= R) begin
                idx = idx - R;
            end
            if (!found && v[idx[IDW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDW-1:0];
            end
        end
        return {found, pick};
    endfunction

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (state_q == ST_LOCKED) begin
            // The owner keeps the grant; everyone else stalls even while it idles.
            gnt_idx = owner_q;
            gnt_any = bus.req_valid[owner_q];
        end else begin
            {gnt_any, gnt_idx} = rr_pick(bus.req_valid, ptr_q);
        end
    end

    assign acc_en = !rsp_valid_q || bus.rsp_ready;
    assign xfer   = !rst && acc_en && gnt_any;

    always_comb begin
        bus.req_ready = '0;
        if (xfer) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    assign add_a  = bus.req_a[int'(gnt_idx) * N +: N];
    assign add_b  = bus.req_b[int'(gnt_idx) * N +: N];
    assign add_ci = bus.req_chain[gnt_idx] ? cy_q[gnt_idx] : bus.req_ci[gnt_idx];
    assign {add_co, add_c} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_ci};

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        cy_d        = cy_q;
        rsp_valid_d = rsp_valid_q;
        rsp_c_d     = rsp_c_q;
        rsp_co_d    = rsp_co_q;
        rsp_id_d    = rsp_id_q;
        if (xfer) begin
            rsp_valid_d   = 1'b1;
            rsp_c_d       = add_c;
            rsp_co_d      = add_co;
            rsp_id_d      = gnt_idx;
            cy_d[gnt_idx] = add_co;
            ptr_d         = (gnt_idx == IDW'(R - 1)) ? '0 : gnt_idx + 1'b1;
            state_d       = bus.req_lock[gnt_idx] ? ST_LOCKED : ST_FREE;
            owner_d       = gnt_idx;
        end else if (bus.rsp_ready) begin
            // Drain keeps the data fields; only valid drops.
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FREE;
            owner_q     <= '0;
            ptr_q       <= '0;
            cy_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_c_q     <= '0;
            rsp_co_q    <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            cy_q        <= cy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_c_q     <= rsp_c_d;
            rsp_co_q    <= rsp_co_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_c      = rsp_c_q;
    assign bus.rsp_co     = rsp_co_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.dbg_locked = (state_q == ST_LOCKED);
    assign bus.dbg_owner  = owner_q;
endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed bench for add_share_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares each accepted response.
module tb_add_share_arbiter;
    localparam int N   = 32;
    localparam int R   = 4;
    localparam int IDW = 2;
    localparam int W   = IDW + 1 + N;

    logic clk = 1'b0;
    logic rst;
    int   tests_run = 0;
    int   fails     = 0;
    logic [W-1:0] exp_q[$];

    add_share_arbiter_if #(.N(N), .R(R)) bus ();
    add_share_arbiter #(.N(N), .R(R)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic ci, input logic chain, input logic lock);
        bus.req_valid[i]       = 1'b1;
        bus.req_a[i*N +: N]    = a;
        bus.req_b[i*N +: N]    = b;
        bus.req_ci[i]          = ci;
        bus.req_chain[i]       = chain;
        bus.req_lock[i]        = lock;
    endtask

    task automatic drop_req(input int i);
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        to_drive();
        rst = 1'b1;
        to_drive();
        rst = 1'b0;
    endtask

    // Checks the grant vector and queues the response the grant should produce.
    task automatic expect_grant(input string name, input logic [R-1:0] exp_rdy,
                                input logic [N-1:0] exp_c, input logic exp_co);
        int id;
        chk(name, 64'(bus.req_ready), 64'(exp_rdy));
        if (exp_rdy != '0) begin
            id = 0;
            for (int k = 0; k < R; k++) begin
                if (exp_rdy[k]) id = k;
            end
            exp_q.push_back({IDW'(id), exp_co, exp_c});
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] want;
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            got = {bus.rsp_id, bus.rsp_co, bus.rsp_c};
            if (exp_q.size() == 0) begin
                tests_run++;
                fails++;
                $display("FAIL rsp_unexpected: got 0x%0h, want no response", got);
            end else begin
                want = exp_q.pop_front();
                chk("rsp", 64'(got), 64'(want));
            end
        end
    end

    logic [R-1:0] rr_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N-1:0] rr_c   [5] = '{32'h100, 32'h201, 32'h302, 32'h403, 32'h100};
    logic [N-1:0] rr_a   [4] = '{32'h100, 32'h200, 32'h300, 32'h400};

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_ci    = '0;
        bus.req_chain = '0;
        bus.req_lock  = '0;
        bus.rsp_ready = 1'b1;

        // Reset state; a request held during reset must not be accepted.
        drive_req(0, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        to_sample();
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_c", 64'(bus.rsp_c), 64'd0);
        chk("rst_rsp_co", 64'(bus.rsp_co), 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        to_drive();
        rst = 1'b0;
        drop_req(0);

        // Single request: 5 + 3 + 1 = 9.
        drive_req(0, 32'h5, 32'h3, 1'b1, 1'b0, 1'b0);
        to_sample();
        expect_grant("t1_grant", 4'b0001, 32'h9, 1'b0);
        to_drive();
        drop_req(0);
        to_sample();
        chk("t1_latency", 64'(bus.rsp_valid), 64'd1);
        to_drive();

        // Round robin from pointer 0, all requesters valid.
        do_reset();
        for (int i = 0; i < R; i++) begin
            drive_req(i, rr_a[i], N'(i), 1'b0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 5; k++) begin
            to_sample();
            expect_grant($sformatf("t2_grant%0d", k), rr_rdy[k], rr_c[k], 1'b0);
            if (k > 0) chk($sformatf("t2_no_bubble%0d", k), 64'(bus.rsp_valid), 64'd1);
            if (k < 4) to_drive();
        end
        to_drive();
        for (int i = 0; i < R; i++) drop_req(i);
        to_sample();
        to_drive();

        // Backpressure: pointer is 1 here.
        drive_req(1, 32'h10, 32'h20, 1'b0, 1'b0, 1'b0);
        to_sample();
        expect_grant("t3_grant1", 4'b0010, 32'h30, 1'b0);
        to_drive();
        drop_req(1);
        drive_req(2, 32'h7, 32'h8, 1'b1, 1'b0, 1'b0);
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            to_sample();
            chk($sformatf("t3_stall_ready%0d", k), 64'(bus.req_ready), 64'd0);
            chk($sformatf("t3_hold_valid%0d", k), 64'(bus.rsp_valid), 64'd1);
            chk($sformatf("t3_hold_c%0d", k), 64'(bus.rsp_c), 64'h30);
            chk($sformatf("t3_hold_id%0d", k), 64'(bus.rsp_id), 64'd1);
            chk($sformatf("t3_hold_co%0d", k), 64'(bus.rsp_co), 64'd0);
            to_drive();
        end
        bus.rsp_ready = 1'b1;
        to_sample();
        expect_grant("t3_grant2", 4'b0100, 32'h10, 1'b0);
        to_drive();
        drop_req(2);
        to_sample();
        to_drive();

        // 64-bit chained add by requester 2 under lock; requester 3 waits.
        do_reset();
        drive_req(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        drive_req(3, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0);
        to_sample();
        expect_grant("t4_word0", 4'b0100, 32'h0, 1'b1);
        to_drive();
        drop_req(2);
        to_sample();
        chk("t4_blocked", 64'(bus.req_ready), 64'd0);
        chk("t4_locked", 64'(bus.dbg_locked), 64'd1);
        to_drive();
        drive_req(2, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0);
        to_sample();
        expect_grant("t4_word1", 4'b0100, 32'h2, 1'b0);
        to_drive();
        drop_req(2);
        to_sample();
        expect_grant("t4_req3", 4'b1000, 32'h33, 1'b0);
        to_drive();
        drop_req(3);
        to_sample();
        to_drive();
        to_sample();
        chk("t4_drain_valid", 64'(bus.rsp_valid), 64'd0);
        chk("t4_drain_hold_c", 64'(bus.rsp_c), 64'h33);

        // Carry wrap.
        to_drive();
        drive_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        to_sample();
        expect_grant("t5_grant", 4'b0001, 32'hFFFF_FFFF, 1'b1);
        to_drive();
        drop_req(0);
        to_sample();
        to_drive();

        // Reset while a response is pending and requester 1 holds the lock.
        drive_req(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        bus.rsp_ready = 1'b0;
        to_sample();
        chk("t6_grant", 64'(bus.req_ready), 64'b0010);
        to_drive();
        drop_req(1);
        to_sample();
        chk("t6_pending", 64'(bus.rsp_valid), 64'd1);
        to_drive();
        rst = 1'b1;
        drive_req(0, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
        drive_req(1, 32'h5, 32'h6, 1'b1, 1'b1, 1'b0);
        to_sample();
        chk("t6_rst_ready", 64'(bus.req_ready), 64'd0);
        to_drive();
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        to_sample();
        chk("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("t6_rsp_c", 64'(bus.rsp_c), 64'd0);
        chk("t6_rsp_co", 64'(bus.rsp_co), 64'd0);
        chk("t6_rsp_id", 64'(bus.rsp_id), 64'd0);
        expect_grant("t6_prio0", 4'b0001, 32'h2, 1'b0);
        to_drive();
        drop_req(0);
        to_sample();
        expect_grant("t6_chain", 4'b0010, 32'hB, 1'b0);
        to_drive();
        drop_req(1);

        for (int k = 0; k < 20; k++) begin
            to_sample();
            if (exp_q.size() == 0) break;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/add_share_arbiter.md
Name: add_share_arbiter

Overview:
- Shares one N-bit combinational add unit (a, b, ci -> c, co) among R requesters.
- Each requester has a valid/ready request channel. One registered response channel carries the result and the requester ID.
- Arbitration is round-robin. A lock/chain facility lets one requester issue a multi-word (multi-precision) add without interleaving, with carry kept between words.
- Sits between several fixed-point clients and a single adder instance.

Parameters:
- N, 32, datapath width in bits.
- R, 4, number of requesters (>=1).
- IDW, $clog2(R) with minimum 1, width of the requester ID (derived localparam).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  R  request present, one bit per requester
- req_ready  output  R  request accepted this cycle, one-hot or zero
- req_a  input  R*N  operand A; requester i uses bits [i*N +: N]
- req_b  input  R*N  operand B; same packing as req_a
- req_ci  input  R  explicit carry-in
- req_chain  input  R  1 = use the stored carry of requester i instead of req_ci
- req_lock  input  R  1 = keep the grant on requester i after this transfer
- rsp_valid  output  1  response present
- rsp_ready  input  1  downstream accepts the response
- rsp_id  output  IDW  requester that issued the response
- rsp_c  output  N  sum
- rsp_co  output  1  carry out

Behaviour:
- Reset values, taking effect on the clock edge with rst=1:
  - rsp_valid=0, rsp_c=0, rsp_co=0, rsp_id=0.
  - Round-robin pointer points at requester 0 (highest priority).
  - Lock state = unlocked.
  - All per-requester carry registers cy[i]=0.
- req_ready is 0 whenever rst=1.
- Accept enable: acc_en = !rsp_valid | rsp_ready.
- Grant when unlocked:
  - Pick the first requester i with req_valid[i]=1, searching from the pointer upward and wrapping modulo R.
  - req_ready[i] = acc_en & granted.
- Grant when locked to owner k:
  - Only k may be granted. Other requesters stall even if k has req_valid=0.
- Transfer: occurs when req_valid[i] & req_ready[i]. Its effective carry-in is eci = req_chain[i] ? cy[i] : req_ci[i]. On the next edge:
  - {rsp_co, rsp_c} <= a + b + eci, computed by the add unit modulo 2^N, with the carry in rsp_co.
  - rsp_id <= i; rsp_valid <= 1.
  - cy[i] <= co.
  - Pointer <= (i+1) mod R.
  - If req_lock[i]=1, lock owner <= i; otherwise unlock.
- Latency and throughput:
  - Latency is 1 cycle: a transfer at edge t gives a valid response after edge t.
  - Throughput is 1 transfer per cycle while rsp_ready=1.
- Response hold: while rsp_valid=1 and rsp_ready=0, rsp_c/rsp_co/rsp_id stay stable and no transfer occurs.
- Response drain: if rsp_valid=1, rsp_ready=1 and there is no new transfer, rsp_valid <= 0. The data fields keep their last value.
- Simultaneous drain and new transfer: the response is replaced in the same cycle, with no bubble.
- Pointer and lock state change only on a transfer.
- Fairness: with no lock held, any requester holding req_valid=1 is granted within R transfers.
- Requester obligation: hold valid and data stable until ready. The block does not check this.
- Reset mid-operation: any pending response is discarded and stored carries are cleared. A lock is released.
- R=1: the pointer is always 0 and IDW=1; rsp_id is always 0.
- Wrap-around: the sum wraps modulo 2^N. Overflow is indicated only by rsp_co.

Test Plan:
- Single request: N=32, R=4. req0 with a=0x0000_0005, b=0x0000_0003, ci=1, rsp_ready=1 -> req_ready[0] in cycle 0; rsp_valid in cycle 1 with rsp_c=0x9, rsp_co=0, rsp_id=0.
- Round-robin: all four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; rsp_id follows the same order one cycle later; no bubbles.
- Backpressure: req1 accepted, then rsp_ready=0 for 3 cycles while req2 is valid -> rsp fields stable; req_ready=0 throughout. When rsp_ready=1, req2 is accepted in the same cycle and its response appears the next cycle.
- 64-bit chained add via lock, by requester 2:
  - Word 0: a=0xFFFF_FFFF, b=0x1, ci=0, lock=1 -> c=0x0, co=1.
  - Requester 3 is valid throughout and is blocked.
  - Word 1: a=0x1, b=0x0, chain=1, lock=0 -> c=0x2, co=0.
  - Requester 3 is granted next.
- Carry wrap: a=0xFFFF_FFFF, b=0xFFFF_FFFF, ci=1 -> rsp_c=0xFFFF_FFFF, rsp_co=1.
- Reset mid-operation: rst=1 while rsp_valid=1 and requester 1 holds a lock -> next cycle rsp_valid=0 and outputs are zero. After rst deasserts, requester 0 has first priority, and a chained add from requester 1 uses carry 0.
